seq_gen: RTL

- Serial bit-sequence generator: the transmit side of the single-bit serial stream (x) consumed by the team's 3-flip-flop sequence-detector FSMs.
- Latches a pattern of up to PAT_W bits on a start request.
- Shifts the pattern out MSB-first, one bit per clk, repeated a programmable number of times with optional idle gaps.
- Drives detector benches and on-chip stimulus.

---
 rtl/seq_gen.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seq_gen.sv
// Serial bit-sequence generator: latches a pattern on start and shifts it out MSB-first,
// repeated reps times with optional idle gaps. Optional even-parity bit: SEQ_GEN_PARITY_EN.
module seq_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_reg;
    logic [PAT_W-1:0] pat_reg;
    logic [IDX_W-1:0] bit_idx_reg;
    logic [IDX_W-1:0] idx_top_reg;
    logic [REP_W-1:0] rep_cnt_reg;
    logic [GAP_W-1:0] gap_len_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             x_reg;
    logic             x_valid_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [LEN_W-1:0] len_c;
    logic [IDX_W-1:0] first_idx;

    // Lengths beyond the pattern width are clamped to the full pattern.
    assign len_c     = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
    assign first_idx = IDX_W'(len_c - LEN_W'(1));

`ifdef SEQ_GEN_PARITY_EN
    logic             par_reg;
    logic             par_phase_reg;
    logic [PAT_W-1:0] masked;

    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
        assign masked[gi] = pattern[gi] & (len_c > LEN_W'(gi));
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            pat_reg     <= '0;
            bit_idx_reg <= '0;
            idx_top_reg <= '0;
            rep_cnt_reg <= '0;
            gap_len_reg <= '0;
            gap_cnt_reg <= '0;
            x_reg       <= 1'b0;
            x_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            par_reg       <= 1'b0;
            par_phase_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start && !abort) begin
                        pat_reg     <= pattern;
                        idx_top_reg <= first_idx;
                        bit_idx_reg <= first_idx;
                        rep_cnt_reg <= reps;
                        gap_len_reg <= gap;
`ifdef SEQ_GEN_PARITY_EN
                        par_reg       <= ^masked;
                        par_phase_reg <= 1'b0;
`endif
                        if (len_c == '0 || reps == '0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg   <= S_SHIFT;
                            x_reg       <= pattern[first_idx];
                            x_valid_reg <= 1'b1;
                            busy_reg    <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        state_reg   <= S_IDLE;
                        x_reg       <= 1'b0;
                        x_valid_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                    end else if (bit_idx_reg != '0) begin
                        bit_idx_reg <= bit_idx_reg - IDX_W'(1);
                        x_reg       <= pat_reg[bit_idx_reg - IDX_W'(1)];
                    end
`ifdef SEQ_GEN_PARITY_EN
                    else if (!par_phase_reg) begin
                        par_phase_reg <= 1'b1;
                        x_reg         <= par_reg;
                    end
`endif
                    else begin
`ifdef SEQ_GEN_PARITY_EN
                        par_phase_reg <= 1'b0;
`endif
                        if (rep_cnt_reg > REP_W'(1)) begin
                            rep_cnt_reg <= rep_cnt_reg - REP_W'(1);
                            if (gap_len_reg != '0) begin
                                state_reg   <= S_GAP;
                                gap_cnt_reg <= gap_len_reg;
                                x_reg       <= 1'b0;
                                x_valid_reg <= 1'b0;
                            end else begin
                                // Back-to-back repetition: x_valid stays high.
                                bit_idx_reg <= idx_top_reg;
                                x_reg       <= pat_reg[idx_top_reg];
                            end
                        end else begin
                            state_reg   <= S_DONE;
                            done_reg    <= 1'b1;
                            busy_reg    <= 1'b0;
                            x_reg       <= 1'b0;
                            x_valid_reg <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state_reg   <= S_IDLE;
                        x_reg       <= 1'b0;
                        x_valid_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                    end else if (gap_cnt_reg == GAP_W'(1)) begin
                        state_reg   <= S_SHIFT;
                        bit_idx_reg <= idx_top_reg;
                        x_reg       <= pat_reg[idx_top_reg];
                        x_valid_reg <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign x       = x_reg;
    assign x_valid = x_valid_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule
